serial_full_adder: RTL and testbench

Parametrised bit-serial full adder: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and computes the sum LSB-first through one full-adder cell and a carry flop. Produces sum, carry-out and signed overflow over a second valid/ready handshake. Successor to the single-bit combinational half adder in the user-project datapath. Trades WIDTH cycles of latency for a one-bit adder footprint.

---
 rtl/serial_full_adder_pkg.sv | 15 +
 rtl/full_adder_cell.sv | 21 ++
 rtl/serial_full_adder.sv | 147 ++++++++++++++
 tb/tb_serial_full_adder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_full_adder_pkg.sv
// serial_full_adder_pkg
// Shared definitions for the bit-serial adder: the controller state
// encoding and the legal range of the WIDTH parameter.
package serial_full_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell
// Combinational one-bit full adder; the only arithmetic in the serial adder.
// Ports:
//   a, b  operand bits
//   ci    carry in
//   s     sum bit
//   co    carry out (majority of a, b, ci)
module full_adder_cell
  import serial_full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_full_adder.sv
// serial_full_adder
// Bit-serial adder: operands arrive over a valid/ready handshake, are
// summed LSB-first through a single full_adder_cell and a carry flop, and
// the result (sum, carry-out, signed overflow) is offered over a second
// valid/ready handshake. Latency is WIDTH cycles after acceptance.
//
// Optional feature: define SERIAL_FULL_ADDER_SUB_EN to enable subtraction
// (sub=1 at acceptance computes a-b; cout=1 then means no borrow). Without
// it the sub input is ignored.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   operand handshake
//   a, b, cin, sub       operands, carry-in, subtract request
//   out_valid, out_ready result handshake
//   sum, cout, ovf       result, carry-out, two's-complement overflow
//   busy                 high while an operation is in RUN or DONE
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one bit per cycle, LSB first
// DONE  | result presented, waiting for out_ready
module serial_full_adder
  import serial_full_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_full_adder: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] bit_cnt;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  full_adder_cell u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  assign in_ready = (state == IDLE);

`ifdef SERIAL_FULL_ADDER_SUB_EN
  // a - b is a + ~b + 1; the incoming cin is ignored when subtracting.
  always_comb begin
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : cin;
  end
`else
  logic unused_sub;
  assign unused_sub = sub;

  always_comb begin
    b_load     = b;
    carry_load = cin;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      bit_cnt   <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b_load;
            carry   <= carry_load;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          carry  <= c_bit;
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (bit_cnt == LAST_BIT) begin
            // Published result only changes here, so it survives the
            // DONE handshake and the following IDLE period untouched.
            sum       <= {s_bit, sum_sh[WIDTH-1:1]};
            cout      <= c_bit;
            ovf       <= carry ^ c_bit;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_full_adder.sv
module tb_serial_full_adder;

  logic clk;
  logic rst;

  logic        in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0, cout0, ovf0, busy0;
  logic [7:0]  a0, b0, sum0;
  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1, busy1;
  logic [15:0] a1, b1, sum1;
  logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2, busy2;
  logic [31:0] a2, b2, sum2;

  int n_vec = 0;
  int n_mis = 0;
  int wid [3] = '{8, 16, 32};

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  serial_full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin0), .sub(sub0), .out_valid(out_valid0),
    .out_ready(out_ready0), .sum(sum0), .cout(cout0), .ovf(ovf0), .busy(busy0)
  );

  serial_full_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  serial_full_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f_sum(int i);
    case (i)
      0: return 32'(sum0);
      1: return 32'(sum1);
      default: return sum2;
    endcase
  endfunction

  function automatic logic f_cout(int i);
    case (i) 0: return cout0; 1: return cout1; default: return cout2; endcase
  endfunction

  function automatic logic f_ovf(int i);
    case (i) 0: return ovf0; 1: return ovf1; default: return ovf2; endcase
  endfunction

  function automatic logic f_ovalid(int i);
    case (i) 0: return out_valid0; 1: return out_valid1; default: return out_valid2; endcase
  endfunction

  function automatic logic f_iready(int i);
    case (i) 0: return in_ready0; 1: return in_ready1; default: return in_ready2; endcase
  endfunction

  function automatic logic f_ivalid(int i);
    case (i) 0: return in_valid0; 1: return in_valid1; default: return in_valid2; endcase
  endfunction

  function automatic logic f_busy(int i);
    case (i) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction

  task automatic set_in(int i, logic v, logic [31:0] av, logic [31:0] bv, logic c, logic s);
    case (i)
      0: begin in_valid0 = v; a0 = av[7:0];  b0 = bv[7:0];  cin0 = c; sub0 = s; end
      1: begin in_valid1 = v; a1 = av[15:0]; b1 = bv[15:0]; cin1 = c; sub1 = s; end
      default: begin in_valid2 = v; a2 = av; b2 = bv; cin2 = c; sub2 = s; end
    endcase
  endtask

  task automatic set_ordy(int i, logic r);
    case (i) 0: out_ready0 = r; 1: out_ready1 = r; default: out_ready2 = r; endcase
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word signed/unsigned arithmetic on 64-bit integers.
  function automatic void model(int w, logic [31:0] av, logic [31:0] bv, logic c, logic s,
                                output res_t r);
    longint full, half, ua, ub, sa, sb, ures, sres;
    logic sub_eff;
`ifdef SERIAL_FULL_ADDER_SUB_EN
    sub_eff = s;
`else
    sub_eff = 1'b0;
`endif
    full = longint'(1) << w;
    half = full / 2;
    ua = longint'(av) & (full - 1);
    ub = longint'(bv) & (full - 1);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    if (sub_eff) begin
      ures = ua - ub;
      sres = sa - sb;
      r.c  = (ua >= ub);
    end else begin
      ures = ua + ub + longint'(c);
      sres = sa + sb + longint'(c);
      r.c  = (ures >= full);
    end
    r.s = 32'(ures & (full - 1));
    r.o = (sres >= half) || (sres < -half);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(int i, logic [31:0] av, logic [31:0] bv, logic c, logic s);
    set_in(i, 1'b1, av, bv, c, s);
    chk("in_ready_before_accept", 32'(f_iready(i)), 32'd1);
    step();
    set_in(i, 1'b0, av, bv, c, s);
    chk("busy_after_accept", 32'(f_busy(i)), 32'd1);
    chk("in_ready_in_run", 32'(f_iready(i)), 32'd0);
  endtask

  task automatic wait_valid(int i, output int cyc);
    cyc = 0;
    while (!f_ovalid(i) && cyc < 200) begin
      step();
      cyc++;
    end
    chk("out_valid_wait", 32'(f_ovalid(i)), 32'd1);
  endtask

  task automatic do_op(string tag, int i, logic [31:0] av, logic [31:0] bv, logic c, logic s,
                       logic [31:0] es, logic ec, logic eo);
    int cyc;
    accept(i, av, bv, c, s);
    wait_valid(i, cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'(wid[i]));
    chk({tag, "_sum"}, f_sum(i), es);
    chk({tag, "_cout"}, 32'(f_cout(i)), 32'(ec));
    chk({tag, "_ovf"}, 32'(f_ovf(i)), 32'(eo));
    set_ordy(i, 1'b1);
    step();
    set_ordy(i, 1'b0);
    chk({tag, "_out_valid_drop"}, 32'(f_ovalid(i)), 32'd0);
    chk({tag, "_idle"}, 32'(f_iready(i)), 32'd1);
  endtask

  task automatic stream(int i, int n_ops);
    res_t exp_q[$];
    res_t e, got;
    int w, n_issued, n_done, last_acc, budget;
    logic [31:0] mask, av, bv;
    logic c, s, acc, done;
    w = wid[i];
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    n_issued = 0;
    n_done = 0;
    last_acc = -1000;
    budget = n_ops * (w + 2) * 4 + 200;
    av = $urandom() & mask;
    bv = $urandom() & mask;
    c = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    set_in(i, 1'b1, av, bv, c, s);
    for (int cyc = 0; cyc < budget && n_done < n_ops; cyc++) begin
      set_ordy(i, 1'($urandom_range(0, 1)));
      #0;
      acc = f_ivalid(i) && f_iready(i);
      done = f_ovalid(i) && (i == 0 ? out_ready0 : i == 1 ? out_ready1 : out_ready2);
      got.s = f_sum(i);
      got.c = f_cout(i);
      got.o = f_ovf(i);
      if (f_iready(i) && f_ovalid(i))
        chk("ready_valid_exclusive", 32'd1, 32'd0);
      step();
      if (acc) begin
        if (n_issued > 0)
          chk("issue_interval", 32'(cyc - last_acc >= w + 2), 32'd1);
        last_acc = cyc;
        model(w, av, bv, c, s, e);
        exp_q.push_back(e);
        n_issued++;
        if (n_issued < n_ops) begin
          av = $urandom() & mask;
          bv = $urandom() & mask;
          c = 1'($urandom_range(0, 1));
          s = 1'($urandom_range(0, 1));
          set_in(i, 1'b1, av, bv, c, s);
        end else begin
          set_in(i, 1'b0, av, bv, c, s);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_sum", got.s, e.s);
          chk("stream_cout", 32'(got.c), 32'(e.c));
          chk("stream_ovf", 32'(got.o), 32'(e.o));
        end
        n_done++;
      end
    end
    set_ordy(i, 1'b0);
    set_in(i, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("stream_complete", 32'(n_done), 32'(n_ops));
  endtask

  initial begin
    int cyc;
    res_t e;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(i, 1'b0, '0, '0, 1'b0, 1'b0);
      set_ordy(i, 1'b0);
    end
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 32'(f_iready(i)), 32'd1);
      chk("rst_out_valid", 32'(f_ovalid(i)), 32'd0);
      chk("rst_busy", 32'(f_busy(i)), 32'd0);
      chk("rst_sum", f_sum(i), 32'd0);
      chk("rst_cout", 32'(f_cout(i)), 32'd0);
      chk("rst_ovf", 32'(f_ovf(i)), 32'd0);
    end
    rst = 1'b0;
    step();

    do_op("add_5a_33", 0, 32'h5A, 32'h33, 1'b0, 1'b0, 32'h8D, 1'b0, 1'b1);
    do_op("add_ff_01", 0, 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0);
    do_op("add_01_01_c", 0, 32'h01, 32'h01, 1'b1, 1'b0, 32'h03, 1'b0, 1'b0);
`ifdef SERIAL_FULL_ADDER_SUB_EN
    do_op("sub_10_20", 0, 32'h10, 32'h20, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b0);
`else
    do_op("sub_10_20", 0, 32'h10, 32'h20, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0);
`endif

    // Backpressure: result must hold while new operands are offered.
    accept(0, 32'h12, 32'h34, 1'b0, 1'b0);
    wait_valid(0, cyc);
    set_in(0, 1'b1, 32'hAA, 32'hBB, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_sum", f_sum(0), 32'h46);
      chk("bp_cout", 32'(f_cout(0)), 32'd0);
      chk("bp_ovf", 32'(f_ovf(0)), 32'd0);
      chk("bp_in_ready", 32'(f_iready(0)), 32'd0);
      chk("bp_out_valid", 32'(f_ovalid(0)), 32'd1);
    end
    set_ordy(0, 1'b1);
    step();
    set_ordy(0, 1'b0);
    chk("bp_release_valid", 32'(f_ovalid(0)), 32'd0);
    chk("bp_release_ready", 32'(f_iready(0)), 32'd1);
    chk("bp_release_sum", f_sum(0), 32'h46);
    step();
    set_in(0, 1'b0, 32'hAA, 32'hBB, 1'b1, 1'b0);
    chk("bp_next_busy", 32'(f_busy(0)), 32'd1);
    wait_valid(0, cyc);
    chk("bp_next_latency", 32'(cyc), 32'd8);
    chk("bp_next_sum", f_sum(0), 32'h66);
    chk("bp_next_cout", 32'(f_cout(0)), 32'd1);
    chk("bp_next_ovf", 32'(f_ovf(0)), 32'd1);
    set_ordy(0, 1'b1);
    step();
    set_ordy(0, 1'b0);

    // Reset in the middle of RUN, at bit 3.
    accept(0, 32'h77, 32'h11, 1'b0, 1'b0);
    repeat (3) step();
    chk("mid_run_busy", 32'(f_busy(0)), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(f_ovalid(0)), 32'd0);
    chk("abort_busy", 32'(f_busy(0)), 32'd0);
    chk("abort_in_ready", 32'(f_iready(0)), 32'd1);
    chk("abort_sum", f_sum(0), 32'd0);
    chk("abort_cout", 32'(f_cout(0)), 32'd0);
    chk("abort_ovf", 32'(f_ovf(0)), 32'd0);
    step();
    rst = 1'b0;
    repeat (10) begin
      step();
      chk("abort_no_result", 32'(f_ovalid(0)), 32'd0);
    end
    model(8, 32'hC3, 32'h5E, 1'b1, 1'b0, e);
    do_op("after_abort", 0, 32'hC3, 32'h5E, 1'b1, 1'b0, e.s, e.c, e.o);

    for (int i = 0; i < 3; i++) stream(i, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
